// File: rtl/weight_ram_stdp.sv
// Per-neuron signed weight store: 1-cycle registered read, 2-stage saturating STDP update, sequenced bulk clear.
// Updates are back-pressured only by a pending or running clear; the read port is never stalled.
module weight_ram_stdp #(
  parameter int M        = 784,
  parameter int N        = 3,
  parameter int W        = 24,
  parameter int AW       = 10,
  parameter int NW       = 2,
  parameter int WMAX     = 65536,
  parameter int WMIN     = -65536,
  parameter int INIT_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic [NW-1:0] rd_neuron,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  input  logic          upd_valid,
  output logic          upd_ready,
  input  logic [NW-1:0] upd_neuron,
  input  logic [AW-1:0] upd_addr,
  input  logic [W-1:0]  upd_delta,
  output logic          upd_sat,
  input  logic          clr_start,
  output logic          busy,
  output logic          clr_done
);

  localparam int DEPTH = N * M;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic signed [W:0] SAT_HI = (W+1)'(WMAX);
  localparam logic signed [W:0] SAT_LO = (W+1)'(WMIN);
  localparam logic [IW-1:0]     LAST   = IW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [W-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic            clr_we;

  logic            rd_ok;
  logic [IW-1:0]   rd_idx;
  logic            upd_ok;
  logic [IW-1:0]   upd_idx;
  logic            upd_fire;

  logic            stg_vld;
  logic            stg_ok;
  logic [IW-1:0]   stg_idx;
  logic [W-1:0]    stg_old;
  logic [W-1:0]    stg_delta;

  logic signed [W:0] sum;
  logic signed [W:0] clamped;
  logic              sat_hit;
  logic [W-1:0]      new_w;
  logic              commit;
  logic              fwd;

  assign rd_ok   = (int'(rd_neuron) < N) && (int'(rd_addr) < M);
  assign rd_idx  = IW'(int'(rd_neuron) * M + int'(rd_addr));
  assign upd_ok  = (int'(upd_neuron) < N) && (int'(upd_addr) < M);
  assign upd_idx = IW'(int'(upd_neuron) * M + int'(upd_addr));

  assign upd_ready = (state_q == IDLE) && !clr_start;
  assign upd_fire  = upd_valid && upd_ready;

  // Sum in W+1 bits so the clamp sees the true overflowed value.
  assign sum = $signed({stg_old[W-1], stg_old}) + $signed({stg_delta[W-1], stg_delta});

  always_comb begin
    clamped = sum;
    sat_hit = 1'b0;
    if (sum > SAT_HI) begin
      clamped = SAT_HI;
      sat_hit = 1'b1;
    end else if (sum < SAT_LO) begin
      clamped = SAT_LO;
      sat_hit = 1'b1;
    end
  end

  assign new_w   = clamped[W-1:0];
  assign commit  = stg_vld && stg_ok;
  assign upd_sat = commit && sat_hit;
  // A new accept to the word being written this cycle must take the fresh result, not the array.
  assign fwd     = commit && upd_ok && (stg_idx == upd_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? mem[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld   <= 1'b0;
      stg_ok    <= 1'b0;
      stg_idx   <= '0;
      stg_old   <= '0;
      stg_delta <= '0;
    end else begin
      stg_vld <= upd_fire;
      if (upd_fire) begin
        stg_ok    <= upd_ok;
        stg_idx   <= upd_idx;
        stg_old   <= fwd ? new_w : mem[upd_idx];
        stg_delta <= upd_delta;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we   = 1'b0;
    busy     = 1'b0;
    clr_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          clr_done = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The update stage is always empty while clearing, so the two writers never collide.
  always_ff @(posedge clk) begin
    if (commit) mem[stg_idx] <= new_w;
    else if (clr_we) mem[cnt_q] <= W'(INIT_VAL);
  end

endmodule
